// File: rtl/key_search_host.sv
// Initiator-side sequencer for the brute-force key search controller: launches a
// search, counts UP attempts, captures the found key and recovers the controller.
module key_search_host #(
    parameter int KEY_W     = 16,
    parameter int MAX_TRIES = 2 ** KEY_W
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             req_i,
    input  logic             abort_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             up_i,
    input  logic             en2_i,
    output logic             start_o,
    output logic             ctl_reset_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             hit_o,
    output logic [KEY_W-1:0] result_key_o,
    output logic [KEY_W:0]   tries_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_SEARCH, S_CAPTURE, S_RELEASE, S_FAIL
    } state_e;

    localparam logic [KEY_W:0] TRIES_MAX = (KEY_W+1)'(MAX_TRIES);
    localparam logic [KEY_W:0] TRIES_ONE = (KEY_W+1)'(1);

    state_e           state_q;
    logic             start_q, ctl_reset_q, busy_q, done_q, hit_q;
    logic [KEY_W-1:0] result_key_q;
    logic [KEY_W:0]   tries_q, tries_d;
    logic [1:0]       grace_q;
    logic             grace_act_q;
    logic             count_up, reach_max, grace_exp;

    always_comb begin
        tries_d   = tries_q + TRIES_ONE;
        count_up  = up_i && (tries_q != TRIES_MAX);
        reach_max = count_up && (tries_d == TRIES_MAX);
        // The decrement that would bring the counter to 0 is the expiry point.
        grace_exp = grace_act_q && (grace_q == 2'd1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            ctl_reset_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            result_key_q <= '0;
            tries_q      <= '0;
            grace_q      <= 2'd0;
            grace_act_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            ctl_reset_q <= 1'b0;
            case (state_q)
                S_IDLE: if (req_i) begin
                    state_q      <= S_LAUNCH;
                    start_q      <= 1'b1;
                    busy_q       <= 1'b1;
                    tries_q      <= '0;
                    hit_q        <= 1'b0;
                    result_key_q <= '0;
                    grace_q      <= 2'd0;
                    grace_act_q  <= 1'b0;
                end
                S_LAUNCH: state_q <= S_SEARCH;
                S_SEARCH: begin
                    if (count_up) tries_q <= tries_d;
                    if (reach_max) begin
                        grace_act_q <= 1'b1;
                        grace_q     <= 2'd2;
                    end else if (grace_act_q && grace_q != 2'd0) begin
                        grace_q <= grace_q - 2'd1;
                    end
                    if (en2_i) begin
                        state_q <= S_CAPTURE;
                    end else if (abort_i || grace_exp) begin
                        // Controller only leaves its search loop via FoundKey or reset.
                        state_q      <= S_FAIL;
                        start_q      <= 1'b0;
                        ctl_reset_q  <= 1'b1;
                        done_q       <= 1'b1;
                        hit_q        <= 1'b0;
                        result_key_q <= '0;
                    end
                end
                S_CAPTURE: begin
                    result_key_q <= key_i;
                    hit_q        <= 1'b1;
                    start_q      <= 1'b0;
                    state_q      <= S_RELEASE;
                end
                S_RELEASE: if (!en2_i) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign start_o      = start_q;
    assign ctl_reset_o  = ctl_reset_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign hit_o        = hit_q;
    assign result_key_o = result_key_q;
    assign tries_o      = tries_q;

endmodule

// File: tb/tb_key_search_host.sv
// Directed bench for key_search_host (KEY_W=4) with a small behavioural model of
// the search controller that emits UP every other cycle and raises en2 on a match.
module tb_key_search_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0, abort = 1'b0;
    logic [3:0] key;
    logic       up, en2;
    logic       start, ctl_reset, busy, done, hit;
    logic [3:0] result_key;
    logic [4:0] tries;

    int vecs = 0;
    int errs = 0;

    logic [3:0] tgt = 4'd0;
    bit         match_en = 1'b0;
    int         hold_cfg = 0;

    key_search_host #(.KEY_W(4)) dut (
        .clk_i(clk), .reset_ni(rst_n), .req_i(req), .abort_i(abort), .key_i(key),
        .up_i(up), .en2_i(en2), .start_o(start), .ctl_reset_o(ctl_reset),
        .busy_o(busy), .done_o(done), .hit_o(hit), .result_key_o(result_key),
        .tries_o(tries)
    );

    always #5 clk = ~clk;

    // Controller model: Idle -> Run (one UP per two cycles) -> Found (en2).
    typedef enum {C_IDLE, C_RUN, C_FOUND} cst_e;
    cst_e cst;
    int   cnt, hold;
    bit   ph;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cst <= C_IDLE; up <= 1'b0; en2 <= 1'b0; cnt <= 0; ph <= 1'b0; key <= 4'd0; hold <= 0;
        end else if (ctl_reset) begin
            cst <= C_IDLE; up <= 1'b0; en2 <= 1'b0; cnt <= 0; ph <= 1'b0; key <= 4'd0; hold <= 0;
        end else begin
            up <= 1'b0;
            case (cst)
                C_IDLE: if (start) begin cst <= C_RUN; cnt <= 0; ph <= 1'b0; end
                C_RUN: begin
                    ph <= ~ph;
                    if (!ph) begin
                        if (cnt != 0 && key == tgt && match_en) begin
                            cst <= C_FOUND; en2 <= 1'b1; hold <= hold_cfg;
                        end else if (cnt < 16) begin
                            up <= 1'b1; key <= cnt[3:0]; cnt <= cnt + 1;
                        end
                    end
                end
                C_FOUND: if (!start) begin
                    if (hold == 0) begin en2 <= 1'b0; cst <= C_IDLE; end
                    else hold <= hold - 1;
                end
                default: cst <= C_IDLE;
            endcase
        end
    end

    task automatic do_req;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vecs++; if (start !== 1'b0)      begin errs++; $display("FAIL rst_start: got %b want 0", start); end
        vecs++; if (ctl_reset !== 1'b0)  begin errs++; $display("FAIL rst_ctl_reset: got %b want 0", ctl_reset); end
        vecs++; if (busy !== 1'b0)       begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
        vecs++; if (done !== 1'b0)       begin errs++; $display("FAIL rst_done: got %b want 0", done); end
        vecs++; if (hit !== 1'b0)        begin errs++; $display("FAIL rst_hit: got %b want 0", hit); end
        vecs++; if (result_key !== 4'd0) begin errs++; $display("FAIL rst_result_key: got %0d want 0", result_key); end
        vecs++; if (tries !== 5'd0)      begin errs++; $display("FAIL rst_tries: got %0d want 0", tries); end
        rst_n = 1'b1;
    endtask

    task automatic test_found;
        int ups = 0, dones = 0, crs = 0, bad_start = 0;
        logic prev_start = 1'b0;
        tgt = 4'd5; match_en = 1'b1; hold_cfg = 0;
        do_req();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (up) ups++;
            if (ctl_reset) crs++;
            if (done) begin dones++; if (prev_start || start) bad_start++; end
            prev_start = start;
        end
        vecs++; if (ups != 6)            begin errs++; $display("FAIL found_ups: got %0d want 6", ups); end
        vecs++; if (hit !== 1'b1)        begin errs++; $display("FAIL found_hit: got %b want 1", hit); end
        vecs++; if (result_key !== 4'd5) begin errs++; $display("FAIL found_key: got %0d want 5", result_key); end
        vecs++; if (tries !== 5'd6)      begin errs++; $display("FAIL found_tries: got %0d want 6", tries); end
        vecs++; if (dones != 1)          begin errs++; $display("FAIL found_done_count: got %0d want 1", dones); end
        vecs++; if (bad_start != 0)      begin errs++; $display("FAIL found_start_before_done: got %0d want 0", bad_start); end
        vecs++; if (crs != 0)            begin errs++; $display("FAIL found_ctl_reset: got %0d want 0", crs); end
        vecs++; if (busy !== 1'b0)       begin errs++; $display("FAIL found_busy: got %b want 0", busy); end
    endtask

    task automatic test_nomatch;
        int ups = 0, dones = 0, crs = 0, t16 = -1, cr_i = -1, dn_i = -1;
        match_en = 1'b0;
        do_req();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (up) ups++;
            if (tries == 5'd16 && t16 < 0) t16 = i;
            if (ctl_reset) begin crs++; cr_i = i; end
            if (done) begin dones++; dn_i = i; end
        end
        vecs++; if (ups != 16)           begin errs++; $display("FAIL nomatch_ups: got %0d want 16", ups); end
        vecs++; if (tries !== 5'd16)     begin errs++; $display("FAIL nomatch_tries: got %0d want 16", tries); end
        vecs++; if (crs != 1)            begin errs++; $display("FAIL nomatch_ctl_reset_count: got %0d want 1", crs); end
        vecs++; if (dones != 1)          begin errs++; $display("FAIL nomatch_done_count: got %0d want 1", dones); end
        vecs++; if (t16 < 0 || cr_i - t16 != 2) begin errs++; $display("FAIL nomatch_grace: got %0d want 2", cr_i - t16); end
        vecs++; if (dn_i != cr_i)        begin errs++; $display("FAIL nomatch_done_align: got %0d want %0d", dn_i, cr_i); end
        vecs++; if (hit !== 1'b0)        begin errs++; $display("FAIL nomatch_hit: got %b want 0", hit); end
        vecs++; if (result_key !== 4'd0) begin errs++; $display("FAIL nomatch_key: got %0d want 0", result_key); end
        vecs++; if (busy !== 1'b0)       begin errs++; $display("FAIL nomatch_busy: got %b want 0", busy); end
    endtask

    task automatic test_abort;
        int ups = 0;
        bit got = 1'b0;
        match_en = 1'b0;
        do_req();
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (up) begin ups++; if (ups == 3) got = 1'b1; end
        end
        vecs++;
        if (!got) begin errs++; $display("FAIL abort_wait_up: got %0d want 3", ups); end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        vecs++; if (ctl_reset !== 1'b1) begin errs++; $display("FAIL abort_ctl_reset: got %b want 1", ctl_reset); end
        vecs++; if (done !== 1'b1)      begin errs++; $display("FAIL abort_done: got %b want 1", done); end
        vecs++; if (tries !== 5'd3)     begin errs++; $display("FAIL abort_tries: got %0d want 3", tries); end
        vecs++; if (hit !== 1'b0)       begin errs++; $display("FAIL abort_hit: got %b want 0", hit); end
        @(negedge clk);
        vecs++; if (busy !== 1'b0)      begin errs++; $display("FAIL abort_busy: got %b want 0", busy); end
        vecs++; if (ctl_reset !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL abort_pulse_width: got %b%b want 00", ctl_reset, done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort_en2;
        int dones = 0, crs = 0;
        bit got = 1'b0;
        tgt = 4'd2; match_en = 1'b1; hold_cfg = 0;
        do_req();
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ctl_reset) crs++;
            if (en2) got = 1'b1;
        end
        vecs++;
        if (!got) begin errs++; $display("FAIL abort_en2_wait: got %b want 1", got); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ctl_reset) crs++;
            if (done) dones++;
            @(negedge clk);
        end
        vecs++; if (crs != 0)            begin errs++; $display("FAIL abort_en2_ctl_reset: got %0d want 0", crs); end
        vecs++; if (dones != 1)          begin errs++; $display("FAIL abort_en2_done: got %0d want 1", dones); end
        vecs++; if (hit !== 1'b1)        begin errs++; $display("FAIL abort_en2_hit: got %b want 1", hit); end
        vecs++; if (result_key !== 4'd2) begin errs++; $display("FAIL abort_en2_key: got %0d want 2", result_key); end
        vecs++; if (tries !== 5'd3)      begin errs++; $display("FAIL abort_en2_tries: got %0d want 3", tries); end
    endtask

    task automatic test_back_to_back;
        int dones = 0, fall_i = -1, dn_i = -1, busy_bad = 0;
        bit pulsed = 1'b0, was_en2 = 1'b0;
        tgt = 4'd3; match_en = 1'b1; hold_cfg = 5;
        do_req();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (was_en2 && !en2 && fall_i < 0) fall_i = i;
            if (done) begin dones++; dn_i = i; end
            if (dones == 0 && !busy) busy_bad++;
            if (!pulsed && busy && !start && en2) begin req = 1'b1; pulsed = 1'b1; end
            was_en2 = en2;
        end
        vecs++; if (!pulsed)             begin errs++; $display("FAIL b2b_req_pulsed: got %b want 1", pulsed); end
        vecs++; if (dones != 1)          begin errs++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
        vecs++; if (fall_i < 0 || dn_i != fall_i + 1) begin errs++; $display("FAIL b2b_done_after_en2: got %0d want %0d", dn_i, fall_i + 1); end
        vecs++; if (busy_bad != 0)       begin errs++; $display("FAIL b2b_busy_early: got %0d want 0", busy_bad); end
        vecs++; if (busy !== 1'b0 || start !== 1'b0) begin errs++; $display("FAIL b2b_req_ignored: got %b%b want 00", busy, start); end
        vecs++; if (hit !== 1'b1)        begin errs++; $display("FAIL b2b_hit: got %b want 1", hit); end
        vecs++; if (result_key !== 4'd3) begin errs++; $display("FAIL b2b_key: got %0d want 3", result_key); end
        vecs++; if (tries !== 5'd4)      begin errs++; $display("FAIL b2b_tries: got %0d want 4", tries); end
    endtask

    task automatic test_reset_mid;
        int crs = 0;
        match_en = 1'b0;
        do_req();
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vecs++; if ({start, ctl_reset, busy, done, hit} !== 5'b0) begin
            errs++; $display("FAIL midrst_flags: got %b want 00000", {start, ctl_reset, busy, done, hit});
        end
        vecs++; if (tries !== 5'd0)      begin errs++; $display("FAIL midrst_tries: got %0d want 0", tries); end
        vecs++; if (result_key !== 4'd0) begin errs++; $display("FAIL midrst_key: got %0d want 0", result_key); end
        repeat (2) begin @(negedge clk); if (ctl_reset) crs++; end
        rst_n = 1'b1;
        tgt = 4'd1; match_en = 1'b1; hold_cfg = 0;
        do_req();
        vecs++; if (start !== 1'b1 || tries !== 5'd0) begin
            errs++; $display("FAIL midrst_restart: got start=%b tries=%0d want start=1 tries=0", start, tries);
        end
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (ctl_reset) crs++; end
        vecs++; if (crs != 0)            begin errs++; $display("FAIL midrst_ctl_reset: got %0d want 0", crs); end
        vecs++; if (hit !== 1'b1)        begin errs++; $display("FAIL midrst_hit: got %b want 1", hit); end
        vecs++; if (result_key !== 4'd1) begin errs++; $display("FAIL midrst_key2: got %0d want 1", result_key); end
        vecs++; if (tries !== 5'd2)      begin errs++; $display("FAIL midrst_tries2: got %0d want 2", tries); end
    endtask

    initial begin
        test_reset();
        test_found();
        test_nomatch();
        test_abort();
        test_abort_en2();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
